// File: rtl/hazard_pkg.sv
// Shared definitions for the 5-stage core hazard controller.
//   state_t : controller sequencing states
//   FWD_*   : Execute-stage operand forwarding selects
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RD  = 2'b00;  // operand read from the D/E register
    localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back in W
    localparam logic [1:0] FWD_ALU = 2'b10;  // ALU result held in M

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives register addresses, write enables and
//            memory status; receives stall/flush/forward controls.
//   slave  : hazard controller side.
interface hazard_controller_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  RA1D, RA2D;
    logic [RA_W-1:0]  RA1E, RA2E;
    logic [RA_W-1:0]  A3E, A3M, A3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE;
    logic             BranchTakenE;
    logic             MemReqM;
    logic             mem_ready;

    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, MemReqM, mem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_error, stall_cnt, flush_cnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, A3E, A3M, A3W,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
               BranchTakenE, MemReqM, mem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, mem_error, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter.
//   clk   : clock, rising edge
//   rst   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard and sequencing controller for the 5-stage 24-bit core.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   bus      : slave side of hazard_controller_if
//              in : RA1D/RA2D, RA1E/RA2E, A3E/A3M/A3W, RegWrite{E,M,W},
//                   MemtoRegE, BranchTakenE, MemReqM, mem_ready
//              out: Stall{F,D,E,M}, Flush{D,E,W}, Forward{A,B}E,
//                   mem_error, stall_cnt, flush_cnt
// Stall/flush/forward outputs are combinational so the pipeline reacts in
// the same cycle the hazard is seen; only sequencing state is registered.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int RA_W        = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    hazard_controller_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              mem_error_q, mem_error_nx;

    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;
    logic [1:0] fwd_a, fwd_b;
    logic lduse;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    // M holds the younger result, so it wins over W for the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [RA_W-1:0] ra,
        input logic [RA_W-1:0] a3m,
        input logic [RA_W-1:0] a3w,
        input logic            wm,
        input logic            ww
    );
        if (wm && (a3m == ra)) return FWD_ALU;
        if (ww && (a3w == ra)) return FWD_WB;
        return FWD_RD;
    endfunction

    assign lduse = bus.MemtoRegE && bus.RegWriteE &&
                   ((bus.A3E == bus.RA1D) || (bus.A3E == bus.RA2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_error_q <= mem_error_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        mem_error_nx = mem_error_q;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        stall_e      = 1'b0;
        stall_m      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;
        flush_w      = 1'b0;

        case (state)
            RUN: begin
                wait_cnt_nx = '0;
                // Memory freeze outranks branch, branch outranks load-use.
                if (bus.MemReqM && !bus.mem_ready) begin
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
                    state_nx = MEM_WAIT;
                end else if (bus.BranchTakenE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lduse) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else begin
                    {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                    // wait_cnt reaches MEM_TIMEOUT on this edge.
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_nx     = ERROR;
                        mem_error_nx = 1'b1;
                    end
                end
            end

            ERROR: begin
                {stall_f, stall_d, stall_e, stall_m, flush_w} = '1;
            end

            default: state_nx = RUN;
        endcase

        // The state register only clears at the edge, so the combinational
        // controls are forced quiet while reset is asserted.
        if (rst) begin
            {stall_f, stall_d, stall_e, stall_m} = '0;
            {flush_d, flush_e, flush_w}          = '0;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(bus.RA1E, bus.A3M, bus.A3W, bus.RegWriteM, bus.RegWriteW);
        fwd_b = fwd_sel(bus.RA2E, bus.A3M, bus.A3W, bus.RegWriteM, bus.RegWriteW);
        if (rst) begin
            fwd_a = FWD_RD;
            fwd_b = FWD_RD;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_f),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_e),
        .count (flush_cnt)
    );

    assign bus.StallF    = stall_f;
    assign bus.StallD    = stall_d;
    assign bus.StallE    = stall_e;
    assign bus.StallM    = stall_m;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.FlushW    = flush_w;
    assign bus.ForwardAE = fwd_a;
    assign bus.ForwardBE = fwd_b;
    assign bus.mem_error = mem_error_q;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios with
// constant expectations, then randomized traffic against a cycle model.
module tb_hazard_controller;

    localparam int RA_W        = 4;
    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    // Control vector order: StallF StallD StallE StallM FlushD FlushE FlushW
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_LDUSE  = 7'b1100010;
    localparam logic [6:0] C_BRANCH = 7'b0000110;
    localparam logic [6:0] C_MEM    = 7'b1111001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_controller_if #(.RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    hazard_controller #(
        .RA_W        (RA_W),
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] ctl;
    assign ctl = {bus.StallF, bus.StallD, bus.StallE, bus.StallM,
                  bus.FlushD, bus.FlushE, bus.FlushW};

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model state ----------------
    bit         m_wait;    // a memory access is holding the pipeline
    int         m_low;     // not-ready cycles since the wait began
    bit         m_err;
    int         m_stall;
    int         m_flush;
    logic [6:0] exp_ctl;
    logic [1:0] exp_fa, exp_fb;

    function automatic logic [1:0] model_fwd(input logic [RA_W-1:0] ra);
        if (bus.RegWriteM && bus.A3M == ra) return 2'b10;
        if (bus.RegWriteW && bus.A3W == ra) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_eval();
        bit ld;
        ld = bus.MemtoRegE && bus.RegWriteE &&
             (bus.A3E == bus.RA1D || bus.A3E == bus.RA2D);
        exp_fa = rst ? 2'b00 : model_fwd(bus.RA1E);
        exp_fb = rst ? 2'b00 : model_fwd(bus.RA2E);
        if (rst)                                exp_ctl = C_NONE;
        else if (m_err)                         exp_ctl = C_MEM;
        else if (m_wait)                        exp_ctl = bus.mem_ready ? C_NONE : C_MEM;
        else if (bus.MemReqM && !bus.mem_ready) exp_ctl = C_MEM;
        else if (bus.BranchTakenE)              exp_ctl = C_BRANCH;
        else if (ld)                            exp_ctl = C_LDUSE;
        else                                    exp_ctl = C_NONE;
    endtask

    task automatic model_advance();
        if (rst) begin
            m_wait = 0; m_low = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (exp_ctl[6] && m_stall < CNT_MAX) m_stall++;
            if (exp_ctl[1] && m_flush < CNT_MAX) m_flush++;
            if (!m_err) begin
                if (m_wait) begin
                    if (bus.mem_ready) begin
                        m_wait = 0;
                        m_low  = 0;
                    end else begin
                        m_low++;
                        if (m_low == MEM_TIMEOUT) begin
                            m_err  = 1;
                            m_wait = 0;
                        end
                    end
                end else if (bus.MemReqM && !bus.mem_ready) begin
                    m_wait = 1;
                    m_low  = 0;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        bus.RA1D = '0; bus.RA2D = '0; bus.RA1E = '0; bus.RA2E = '0;
        bus.A3E = '0; bus.A3M = '0; bus.A3W = '0;
        bus.RegWriteE = 0; bus.RegWriteM = 0; bus.RegWriteW = 0;
        bus.MemtoRegE = 0; bus.BranchTakenE = 0;
        bus.MemReqM = 0; bus.mem_ready = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_lduse();
        bus.MemtoRegE = 1; bus.RegWriteE = 1;
        bus.A3E = 4'd2; bus.RA2D = 4'd2; bus.RA1D = 4'd7;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        bus.RegWriteM = 1; bus.A3M = 4'd3; bus.RA1E = 4'd3; bus.RA2E = 4'd3;
        bus.BranchTakenE = 1; bus.MemReqM = 1;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            failures++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_NONE);
        end
        checks++;
        if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_fwd: got %b/%b expected 00/00", bus.ForwardAE, bus.ForwardBE);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({bus.mem_error, bus.stall_cnt, bus.flush_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d expected 0/0/0",
                     bus.mem_error, bus.stall_cnt, bus.flush_cnt);
        end
        rst = 0;
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        bus.RA1E = 4'd3; bus.A3M = 4'd3; bus.RegWriteM = 1;
        bus.A3W = 4'd3; bus.RegWriteW = 1; bus.RA2E = 4'd5;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b10) begin
            failures++; $display("FAIL fwd_a_m_priority: got %b expected 10", bus.ForwardAE);
        end
        checks++;
        if (bus.ForwardBE !== 2'b00) begin
            failures++; $display("FAIL fwd_b_nomatch: got %b expected 00", bus.ForwardBE);
        end
        @(negedge clk);
        bus.RegWriteM = 0;
        #1;
        checks++;
        if (bus.ForwardAE !== 2'b01) begin
            failures++; $display("FAIL fwd_a_w: got %b expected 01", bus.ForwardAE);
        end
        @(negedge clk);
        bus.RegWriteM = 1; bus.A3M = 4'd5;
        #1;
        checks++;
        if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0110) begin
            failures++;
            $display("FAIL fwd_split: got %b/%b expected 01/10", bus.ForwardAE, bus.ForwardBE);
        end
        checks++;
        if (ctl !== C_NONE) begin
            failures++; $display("FAIL fwd_ctl_quiet: got %b expected %b", ctl, C_NONE);
        end
    endtask

    task automatic test_load_use();
        pulse_reset();
        @(negedge clk);
        clear_inputs();
        set_lduse();
        #1;
        checks++;
        if (ctl !== C_LDUSE) begin
            failures++; $display("FAIL lduse_ctl: got %b expected %b", ctl, C_LDUSE);
        end
        @(negedge clk);   // load has moved on to M
        clear_inputs();
        bus.A3M = 4'd2; bus.RegWriteM = 1;
        #1;
        checks++;
        if (ctl !== C_NONE) begin
            failures++; $display("FAIL lduse_one_cycle: got %b expected %b", ctl, C_NONE);
        end
        checks++;
        if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin
            failures++;
            $display("FAIL lduse_counts: got stall=%0d flush=%0d expected 1/1",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_branch_over_lduse();
        @(negedge clk);
        clear_inputs();
        set_lduse();
        bus.BranchTakenE = 1;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            failures++; $display("FAIL branch_lduse_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd2) begin
            failures++;
            $display("FAIL branch_counts: got stall=%0d flush=%0d expected 1/2",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        logic [6:0] exp_seq [0:3];
        exp_seq = '{C_MEM, C_MEM, C_MEM, C_NONE};
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.MemReqM      = 1;
            bus.mem_ready    = (c == 3);
            bus.BranchTakenE = (c == 1);
            #1;
            checks++;
            if (ctl !== exp_seq[c]) begin
                failures++;
                $display("FAIL mem_wait_c%0d: got %b expected %b", c + 1, ctl, exp_seq[c]);
            end
        end
        @(negedge clk);   // frozen branch re-asserts after release
        clear_inputs();
        bus.BranchTakenE = 1;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            failures++; $display("FAIL mem_branch_reassert: got %b expected %b", ctl, C_BRANCH);
        end
        checks++;
        if (bus.stall_cnt !== 4'd3 || bus.flush_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mem_wait_counts: got stall=%0d flush=%0d expected 3/0",
                     bus.stall_cnt, bus.flush_cnt);
        end
        @(negedge clk);   // ready access in RUN does not freeze
        clear_inputs();
        bus.MemReqM = 1; bus.mem_ready = 1;
        set_lduse();
        #1;
        checks++;
        if (ctl !== C_LDUSE) begin
            failures++; $display("FAIL mem_ready_run: got %b expected %b", ctl, C_LDUSE);
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            clear_inputs();
            bus.MemReqM   = (c < 7);
            bus.mem_ready = (c == 7);   // too late: error state ignores it
            #1;
            checks++;
            if (ctl !== C_MEM) begin
                failures++; $display("FAIL timeout_ctl_c%0d: got %b expected %b", c, ctl, C_MEM);
            end
            checks++;
            if (bus.mem_error !== (c >= 6)) begin
                failures++;
                $display("FAIL timeout_err_c%0d: got %b expected %b", c, bus.mem_error, c >= 6);
            end
        end
        @(negedge clk);
        clear_inputs();
        rst = 1;
        #1;
        checks++;
        if (ctl !== C_NONE || bus.stall_cnt !== 4'd7) begin
            failures++;
            $display("FAIL timeout_rst_cycle: got ctl=%b stall=%0d expected %b/7",
                     ctl, bus.stall_cnt, C_NONE);
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if ({ctl, bus.mem_error, bus.stall_cnt, bus.flush_cnt} !== '0) begin
            failures++;
            $display("FAIL timeout_after_rst: got ctl=%b err=%b stall=%0d flush=%0d expected all 0",
                     ctl, bus.mem_error, bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            clear_inputs();
            set_lduse();
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd15 || bus.flush_cnt !== 4'd15) begin
            failures++;
            $display("FAIL saturation: got stall=%0d flush=%0d expected 15/15",
                     bus.stall_cnt, bus.flush_cnt);
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        pulse_reset();
        m_wait = 0; m_low = 0; m_err = 0; m_stall = 0; m_flush = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst               = ($urandom_range(0, 59) == 0);
            bus.RA1D          = RA_W'($urandom_range(0, 3));
            bus.RA2D          = RA_W'($urandom_range(0, 3));
            bus.RA1E          = RA_W'($urandom_range(0, 3));
            bus.RA2E          = RA_W'($urandom_range(0, 3));
            bus.A3E           = RA_W'($urandom_range(0, 3));
            bus.A3M           = RA_W'($urandom_range(0, 3));
            bus.A3W           = RA_W'($urandom_range(0, 3));
            bus.RegWriteE     = $urandom_range(0, 1) == 1;
            bus.RegWriteM     = $urandom_range(0, 1) == 1;
            bus.RegWriteW     = $urandom_range(0, 1) == 1;
            bus.MemtoRegE     = $urandom_range(0, 1) == 1;
            bus.BranchTakenE  = $urandom_range(0, 4) == 0;
            bus.MemReqM       = $urandom_range(0, 2) == 0;
            bus.mem_ready     = $urandom_range(0, 1) == 1;
            #1;
            model_eval();
            checks++;
            if (ctl !== exp_ctl || bus.ForwardAE !== exp_fa || bus.ForwardBE !== exp_fb ||
                bus.mem_error !== m_err ||
                bus.stall_cnt !== CNT_W'(m_stall) || bus.flush_cnt !== CNT_W'(m_flush)) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_c%0d: got ctl=%b fa=%b fb=%b err=%b st=%0d fl=%0d expected ctl=%b fa=%b fb=%b err=%b st=%0d fl=%0d",
                             c, ctl, bus.ForwardAE, bus.ForwardBE, bus.mem_error,
                             bus.stall_cnt, bus.flush_cnt, exp_ctl, exp_fa, exp_fb,
                             m_err, m_stall, m_flush);
            end
            model_advance();
        end
        @(negedge clk);
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_over_lduse();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
